// File: rtl/alu_result_stage.sv
// Purpose: small in-order queue between the ALU and writeback; captures HI/LO from mul/div results as they retire.
// Latency: one cycle from accepted push to visible head (no bypass); HI/LO update on the same edge the mul/div entry pops.
// Backpressure: in_ready drops when the queue is full (registered count only); entries wait while out_ready is low.
//
// Optional build macro ALU_RESULT_FLAGS_EN adds out_zero/out_neg head flags.
module alu_result_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  alu_sel,
    input  logic [63:0] alu_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z_out,
    output logic        out_err,
    output logic [31:0] hi,
    output logic [31:0] lo
`ifdef ALU_RESULT_FLAGS_EN
    ,
    output logic        out_zero,
    output logic        out_neg
`endif
);

    // DEPTH is restricted to powers of two in 2..8, so pointers wrap naturally.
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 5 + 64;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          push;
    logic          pop;
    logic          empty;
    logic [EW-1:0] head_entry;
    logic [4:0]    head_sel;
    logic          head_err;
    logic          head_muldiv;

    // Handshake decode and head-entry field extraction.
    always_comb begin
        empty       = (count == '0);
        in_ready    = (count != FULL_CNT);
        out_valid   = !empty;
        push        = in_valid && in_ready;
        pop         = out_valid && out_ready;
        head_entry  = mem[rd_ptr];
        head_sel    = head_entry[68:64];
        // 3 and 15..31 are not assigned to any ALU operation.
        head_err    = (head_sel == 5'd3) || (head_sel >= 5'd15);
        head_muldiv = (head_sel == 5'd2) || (head_sel == 5'd4);
    end

    // Head outputs are forced to zero when nothing is queued so stale storage never leaks.
    always_comb begin
        z_out   = '0;
        out_err = 1'b0;
        if (!empty) begin
            z_out   = head_entry[31:0];
            out_err = head_err;
        end
    end

`ifdef ALU_RESULT_FLAGS_EN
    // Zero/negative flags derived from the head result, cleared when empty.
    always_comb begin
        out_zero = 1'b0;
        out_neg  = 1'b0;
        if (!empty) begin
            out_zero = (head_entry[31:0] == 32'd0);
            out_neg  = head_entry[31];
        end
    end
`endif

    // Queue storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem[wr_ptr] <= {alu_sel, alu_out};
        end
    end

    // Pointer and occupancy bookkeeping; reset wins over any push/pop in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // HI/LO take the full 64-bit mul/div result as that entry retires; everything else leaves them alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (pop && head_muldiv) begin
            hi <= head_entry[63:32];
            lo <= head_entry[31:0];
        end
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: DEPTH, default 2, number of result-queue entries; SHALL be a power of two in 2..8.
REQ-002 Port: clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  ALU result presented.
REQ-005 Port: in_ready  output  1  stage can accept a result.
REQ-006 Port: alu_sel  input  5  operation code that produced alu_out (0 add, 1 sub, 2 mul, 4 div, 5..14 logic/shift).
REQ-007 Port: alu_out  input  64  ALU result; mul = {hi,lo} product, div = {remainder,quotient}.
REQ-008 Port: out_valid  output  1  head entry available to writeback.
REQ-009 Port: out_ready  input  1  writeback consumes head entry.
REQ-010 Port: z_out  output  32  head entry bits [31:0].
REQ-011 Port: out_err  output  1  head entry carries an undefined alu_sel (3 or 15..31).
REQ-012 Port: hi  output  32  architectural HI register.
REQ-013 Port: lo  output  32  architectural LO register.

Function
REQ-014 Queue entry SHALL hold {alu_sel, alu_out}; push SHALL occur when in_valid && in_ready.
REQ-015 in_ready SHALL equal !full, combinationally from registered count only; a push SHALL NOT occur when full, even with a simultaneous pop.
REQ-016 out_valid SHALL equal !empty; pop SHALL occur when out_valid && out_ready.
REQ-017 No bypass: a result pushed in cycle N SHALL first appear on out_valid/z_out in cycle N+1.
REQ-018 Simultaneous push and pop when neither full nor empty SHALL leave count unchanged and preserve order.
REQ-019 Read/write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0; count SHALL be log2(DEPTH)+1 bits.
REQ-020 z_out and out_err SHALL reflect the head entry whenever out_valid=1 and SHALL be 0 when empty.
REQ-021 On pop of a head entry with alu_sel 2 or 4, hi <= entry[63:32] and lo <= entry[31:0] in the same edge; otherwise hi/lo SHALL hold.
REQ-022 Entries with undefined alu_sel SHALL be queued and popped normally with out_err=1 and SHALL NOT update hi/lo.
REQ-023 Inputs alu_sel/alu_out SHALL be ignored when in_valid=0; the queue SHALL NOT change.

Reset
REQ-024 While reset=1 at a clock edge: pointers, count, hi, lo SHALL clear to 0; in_ready SHALL be 1 and out_valid 0 in the following cycle.
REQ-025 Reset SHALL take priority over simultaneous push/pop; queued entries SHALL be discarded.
REQ-026 Queue storage contents SHALL NOT require reset.

Configuration
REQ-027 Macro ALU_RESULT_FLAGS_EN: when defined, ports out_zero (1, head z_out == 0) and out_neg (1, head z_out[31]) SHALL exist, both 0 when empty.
REQ-028 Without ALU_RESULT_FLAGS_EN those ports and their logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset, then push sel=0 alu_out=0x0000_0000_0000_0007 -> next cycle out_valid=1, z_out=0x7, hi=lo=0.
REQ-030 Push sel=2 alu_out=0x0000_0001_8000_0000, pop -> after pop edge hi=0x0000_0001, lo=0x8000_0000; subsequent sel=5 pop leaves hi/lo unchanged.
REQ-031 DEPTH=2: push 3 results back-to-back with out_ready=0 -> in_ready=0 after second push, third held; pop once -> third accepted, order 1,2,3 preserved.
REQ-032 Push sel=3 -> out_err=1 at head, hi/lo unchanged after pop.
REQ-033 Queue holding 2 entries, reset=1 for one edge with in_valid=1 and out_ready=1 -> out_valid=0, in_ready=1, hi=lo=0 next cycle.
REQ-034 With ALU_RESULT_FLAGS_EN: push sel=1 alu_out=0x0000_0000_FFFF_FFFF -> out_neg=1, out_zero=0; push 0 -> out_zero=1.
